sync_filter_bank: RTL and testbench



---
 rtl/sync_filter_bank.sv | 101 ++++++++++
 tb/tb_sync_filter_bank.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_filter_bank.sv
`default_nettype none
// ============================================================================
// Module   : sync_filter_bank
// Brief    : Per-channel synchroniser chain, consecutive-sample glitch filter
//            and registered rise/fall edge pulses for WIDTH async inputs.
// Revision : 1.0
// ============================================================================
module sync_filter_bank #(
    parameter int               WIDTH      = 4,
    parameter int               STAGES     = 3,
    parameter int               FILTER_LEN = 4,
    parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_edge
);

    localparam int                 c_cnt_w    = $clog2(FILTER_LEN + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILTER_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [WIDTH-1:0] w_flip;
    logic             r_any_edge;

    if (STAGES < 2) begin : g_stages_check
        $error("sync_filter_bank: STAGES must be >= 2");
    end

    if (FILTER_LEN < 1) begin : g_filter_check
        $error("sync_filter_bank: FILTER_LEN must be >= 1");
    end

    if (WIDTH < 1) begin : g_width_check
        $error("sync_filter_bank: WIDTH must be >= 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic [STAGES-1:0]  r_sync;
        logic [c_cnt_w-1:0] r_cnt;
        logic               r_out;
        logic               r_rise;
        logic               r_fall;
        logic               w_synced;
        logic               w_differ;

        assign w_synced  = r_sync[STAGES-1];
        assign w_differ  = (w_synced != r_out);
        assign w_flip[i] = w_differ && (r_cnt == c_cnt_last);

        // Bare flop chain: nothing may sit between stages.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync <= {STAGES{RESET_VAL[i]}};
            end else begin
                r_sync <= {r_sync[STAGES-2:0], async_in[i]};
            end
        end

        // Counter only grows during an unbroken run of disagreement.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt  <= '0;
                r_out  <= RESET_VAL[i];
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else begin
                r_rise <= w_flip[i] & w_synced;
                r_fall <= w_flip[i] & ~w_synced;
                if (!w_differ) begin
                    r_cnt <= '0;
                end else if (w_flip[i]) begin
                    r_out <= w_synced;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end
        end

        assign sync_out[i] = r_out;
        assign rise[i]     = r_rise;
        assign fall[i]     = r_fall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_any_edge <= 1'b0;
        end else begin
            r_any_edge <= |w_flip;
        end
    end

    assign any_edge = r_any_edge;

endmodule
`default_nettype wire

// File: tb/tb_sync_filter_bank.sv
`default_nettype none
// Directed bench for sync_filter_bank: three builds (default, RESET_VAL=0101,
// STAGES=2/FILTER_LEN=1) sharing one clock and reset.
module tb_sync_filter_bank;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;

    logic [3:0] a_in = 4'b0000;
    logic [3:0] a_out, a_rise, a_fall;
    logic       a_any;
    logic [3:0] r_in = 4'b0000;
    logic [3:0] r_out, r_rise, r_fall;
    logic       r_any;
    logic [3:0] f_in = 4'b0000;
    logic [3:0] f_out, f_rise, f_fall;
    logic       f_any;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sync_filter_bank #(.WIDTH(4), .STAGES(3), .FILTER_LEN(4), .RESET_VAL(4'b0000)) dut_a (
        .clk(clk), .rst_n(rst_n), .async_in(a_in),
        .sync_out(a_out), .rise(a_rise), .fall(a_fall), .any_edge(a_any)
    );

    sync_filter_bank #(.WIDTH(4), .STAGES(3), .FILTER_LEN(4), .RESET_VAL(4'b0101)) dut_r (
        .clk(clk), .rst_n(rst_n), .async_in(r_in),
        .sync_out(r_out), .rise(r_rise), .fall(r_fall), .any_edge(r_any)
    );

    sync_filter_bank #(.WIDTH(4), .STAGES(2), .FILTER_LEN(1), .RESET_VAL(4'b0000)) dut_f (
        .clk(clk), .rst_n(rst_n), .async_in(f_in),
        .sync_out(f_out), .rise(f_rise), .fall(f_fall), .any_edge(f_any)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_out, exp_fall;
        rst_n = 1'b0;
        for (int t = 0; t < 6; t++) begin
            a_in = ~a_in;
            r_in = 4'(t);
            f_in = ~f_in;
            tick();
            n_cmp++;
            if (r_out !== 4'b0101 || r_rise !== 4'b0000 || r_fall !== 4'b0000 || r_any !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold_r t=%0d got out=%b rise=%b fall=%b any=%b exp out=0101 others 0",
                         t, r_out, r_rise, r_fall, r_any);
            end
            n_cmp++;
            if (a_out !== 4'b0000 || a_any !== 1'b0 || f_out !== 4'b0000 || f_any !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold_af t=%0d got a_out=%b a_any=%b f_out=%b f_any=%b exp all 0",
                         t, a_out, a_any, f_out, f_any);
            end
        end
        a_in  = 4'b0000;
        r_in  = 4'b0000;
        f_in  = 4'b0000;
        rst_n = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            exp_out  = (e >= 7) ? 4'b0000 : 4'b0101;
            exp_fall = (e == 7) ? 4'b0101 : 4'b0000;
            n_cmp++;
            if (r_out !== exp_out || r_fall !== exp_fall || r_rise !== 4'b0000 || r_any !== (e == 7)) begin
                n_err++;
                $display("FAIL release_r e=%0d got out=%b fall=%b rise=%b any=%b exp out=%b fall=%b rise=0000 any=%0d",
                         e, r_out, r_fall, r_rise, r_any, exp_out, exp_fall, (e == 7));
            end
            n_cmp++;
            if (a_out !== 4'b0000 || a_rise !== 4'b0000 || a_fall !== 4'b0000 || a_any !== 1'b0) begin
                n_err++;
                $display("FAIL release_a e=%0d got out=%b rise=%b fall=%b any=%b exp all 0",
                         e, a_out, a_rise, a_fall, a_any);
            end
        end
    endtask

    task automatic test_latency();
        logic [3:0] exp_out, exp_rise;
        a_in = 4'b0001;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_out  = (e >= 7) ? 4'b0001 : 4'b0000;
            exp_rise = (e == 7) ? 4'b0001 : 4'b0000;
            n_cmp++;
            if (a_out !== exp_out || a_rise !== exp_rise || a_fall !== 4'b0000 || a_any !== (e == 7)) begin
                n_err++;
                $display("FAIL latency e=%0d got out=%b rise=%b fall=%b any=%b exp out=%b rise=%b fall=0000 any=%0d",
                         e, a_out, a_rise, a_fall, a_any, exp_out, exp_rise, (e == 7));
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] exp_out, exp_rise, exp_fall;
        for (int t = 0; t < 14; t++) begin
            a_in[1] = (t < 3);
            tick();
            n_cmp++;
            if (a_out !== 4'b0001 || a_rise !== 4'b0000 || a_fall !== 4'b0000 || a_any !== 1'b0) begin
                n_err++;
                $display("FAIL glitch3 t=%0d got out=%b rise=%b fall=%b any=%b exp out=0001 no pulses",
                         t, a_out, a_rise, a_fall, a_any);
            end
        end
        for (int t = 0; t < 14; t++) begin
            a_in[1] = (t < 4);
            tick();
            exp_out  = (t + 1 >= 7 && t + 1 <= 10) ? 4'b0011 : 4'b0001;
            exp_rise = (t + 1 == 7)  ? 4'b0010 : 4'b0000;
            exp_fall = (t + 1 == 11) ? 4'b0010 : 4'b0000;
            n_cmp++;
            if (a_out !== exp_out || a_rise !== exp_rise || a_fall !== exp_fall ||
                a_any !== (t + 1 == 7 || t + 1 == 11)) begin
                n_err++;
                $display("FAIL pulse4 e=%0d got out=%b rise=%b fall=%b any=%b exp out=%b rise=%b fall=%b",
                         t + 1, a_out, a_rise, a_fall, a_any, exp_out, exp_rise, exp_fall);
            end
        end
    endtask

    task automatic test_interrupted();
        for (int t = 0; t < 16; t++) begin
            a_in[1] = (t < 3) || (t >= 4 && t < 7);
            tick();
            n_cmp++;
            if (a_out !== 4'b0001 || a_rise !== 4'b0000 || a_fall !== 4'b0000 || a_any !== 1'b0) begin
                n_err++;
                $display("FAIL interrupted t=%0d got out=%b rise=%b fall=%b any=%b exp out=0001 no pulses",
                         t, a_out, a_rise, a_fall, a_any);
            end
        end
    endtask

    task automatic test_multi();
        logic [3:0] exp_out, exp_rise;
        a_in = 4'b0000;
        for (int t = 0; t < 10; t++) tick();
        n_cmp++;
        if (a_out !== 4'b0000) begin
            n_err++;
            $display("FAIL multi_idle got out=%b exp 0000", a_out);
        end
        a_in = 4'b1111;
        for (int e = 1; e <= 9; e++) begin
            tick();
            exp_out  = (e >= 7) ? 4'b1111 : 4'b0000;
            exp_rise = (e == 7) ? 4'b1111 : 4'b0000;
            n_cmp++;
            if (a_out !== exp_out || a_rise !== exp_rise || a_fall !== 4'b0000 || a_any !== (e == 7)) begin
                n_err++;
                $display("FAIL multi e=%0d got out=%b rise=%b fall=%b any=%b exp out=%b rise=%b any=%0d",
                         e, a_out, a_rise, a_fall, a_any, exp_out, exp_rise, (e == 7));
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] exp_out, exp_rise;
        a_in = 4'b0101;
        for (int t = 0; t < 10; t++) tick();
        n_cmp++;
        if (a_out !== 4'b0101) begin
            n_err++;
            $display("FAIL midrst_setup got out=%b exp 0101", a_out);
        end
        a_in = 4'b0111;
        for (int t = 0; t < 5; t++) begin
            tick();
            n_cmp++;
            if (a_out !== 4'b0101 || a_rise !== 4'b0000) begin
                n_err++;
                $display("FAIL midrst_pending t=%0d got out=%b rise=%b exp out=0101 rise=0000", t, a_out, a_rise);
            end
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (a_out !== 4'b0000 || a_rise !== 4'b0000 || a_fall !== 4'b0000 || a_any !== 1'b0 || r_out !== 4'b0101) begin
            n_err++;
            $display("FAIL midrst_async got a_out=%b rise=%b fall=%b any=%b r_out=%b exp 0000/0/0/0 r_out=0101",
                     a_out, a_rise, a_fall, a_any, r_out);
        end
        for (int t = 0; t < 2; t++) begin
            tick();
            n_cmp++;
            if (a_out !== 4'b0000 || a_rise !== 4'b0000 || a_any !== 1'b0) begin
                n_err++;
                $display("FAIL midrst_hold t=%0d got out=%b rise=%b any=%b exp all 0", t, a_out, a_rise, a_any);
            end
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            exp_out  = (e >= 7) ? 4'b0111 : 4'b0000;
            exp_rise = (e == 7) ? 4'b0111 : 4'b0000;
            n_cmp++;
            if (a_out !== exp_out || a_rise !== exp_rise || a_fall !== 4'b0000 || a_any !== (e == 7)) begin
                n_err++;
                $display("FAIL midrst_release e=%0d got out=%b rise=%b fall=%b any=%b exp out=%b rise=%b any=%0d",
                         e, a_out, a_rise, a_fall, a_any, exp_out, exp_rise, (e == 7));
            end
        end
    endtask

    task automatic test_filter1();
        bit         exp_o [0:14];
        logic [3:0] exp_out, exp_rise, exp_fall;
        exp_o = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
        for (int t = 0; t < 14; t++) begin
            f_in[2] = (t < 12) && (((t / 2) % 2) == 0);
            tick();
            exp_out  = {1'b0, exp_o[t+1], 2'b00};
            exp_rise = {1'b0, exp_o[t+1] & ~exp_o[t], 2'b00};
            exp_fall = {1'b0, ~exp_o[t+1] & exp_o[t], 2'b00};
            n_cmp++;
            if (f_out !== exp_out || f_rise !== exp_rise || f_fall !== exp_fall ||
                f_any !== (exp_o[t+1] != exp_o[t])) begin
                n_err++;
                $display("FAIL filter1 e=%0d got out=%b rise=%b fall=%b any=%b exp out=%b rise=%b fall=%b",
                         t + 1, f_out, f_rise, f_fall, f_any, exp_out, exp_rise, exp_fall);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_out, exp_rise, exp_fall;
        for (int t = 0; t < 6; t++) begin
            f_in[2] = (t == 0);
            tick();
            exp_out  = (t + 1 == 3) ? 4'b0100 : 4'b0000;
            exp_rise = (t + 1 == 3) ? 4'b0100 : 4'b0000;
            exp_fall = (t + 1 == 4) ? 4'b0100 : 4'b0000;
            n_cmp++;
            if (f_out !== exp_out || f_rise !== exp_rise || f_fall !== exp_fall ||
                f_any !== (t + 1 == 3 || t + 1 == 4)) begin
                n_err++;
                $display("FAIL back_to_back e=%0d got out=%b rise=%b fall=%b any=%b exp out=%b rise=%b fall=%b",
                         t + 1, f_out, f_rise, f_fall, f_any, exp_out, exp_rise, exp_fall);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_interrupted();
        test_multi();
        test_mid_reset();
        test_filter1();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
